// File: rtl/wb_commit_pkg.sv
// Shared constants for the writeback commit stage:
// load funct3 encodings and FSM state codes.
package wb_commit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic ST_IDLE      = 1'b0;
    localparam logic ST_LOAD_WAIT = 1'b1;

endpackage

// File: rtl/wb_load_align.sv
// Load data aligner: selects byte/half from the raw dmem word
// and sign- or zero-extends it to XLEN.
module wb_load_align
    import wb_commit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Half select ignores addr_lo[0]; misaligned halves trap upstream.
    assign byte_sel = data[{addr_lo, 3'b000} +: 8];
    assign half_sel = data[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        result = data;
        unique case (1'b1)
            funct3 == F3_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            funct3 == F3_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
            funct3 == F3_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
            funct3 == F3_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
            funct3 == F3_LW:  result = data;
            default:          result = data;
        endcase
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit stage: one registered GPR write port, load wait
// with back-pressure, and the instret retire counter.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk_i,
    input  logic                  n_rst_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic                  flush_i,
    input  logic                  mem_rd_we_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_wa_i,
    input  logic [XLEN-1:0]       mem_rd_wd_i,
    input  logic                  mem_is_load_i,
    input  logic [2:0]            mem_ld_funct3_i,
    input  logic [1:0]            mem_addr_lo_i,
    input  logic                  dmem_rsp_valid_i,
    input  logic [XLEN-1:0]       dmem_rsp_data_i,
    output logic                  rd_we_o,
    output logic [REG_ADDR_W-1:0] rd_wa_o,
    output logic [XLEN-1:0]       rd_wd_o,
    output logic                  retire_o,
    output logic [CNT_W-1:0]      instret_o
);

    logic                  state_q;
    logic                  ld_we_q;
    logic [REG_ADDR_W-1:0] ld_wa_q;
    logic [2:0]            ld_f3_q;
    logic [1:0]            ld_lo_q;

    logic                  pnd_v_q;
    logic                  pnd_we_q;
    logic [REG_ADDR_W-1:0] pnd_wa_q;
    logic [XLEN-1:0]       pnd_wd_q;

    logic                  rsp_hit;
    logic                  accept;
    logic                  acc_alu;
    logic                  acc_ld;
    logic                  alu_we;
    logic                  commit;
    logic [XLEN-1:0]       ld_data;

    assign rsp_hit     = (state_q == ST_LOAD_WAIT) & dmem_rsp_valid_i;
    assign mem_ready_o = (state_q == ST_IDLE) | rsp_hit;
    assign accept      = mem_valid_i & ~flush_i & mem_ready_o;
    assign acc_alu     = accept & ~mem_is_load_i;
    assign acc_ld      = accept & mem_is_load_i;
    assign alu_we      = mem_rd_we_i & (mem_rd_wa_i != '0);
    assign commit      = pnd_v_q | rsp_hit | acc_alu;

    wb_load_align #(
        .XLEN(XLEN)
    ) u_align (
        .funct3 (ld_f3_q),
        .addr_lo(ld_lo_q),
        .data   (dmem_rsp_data_i),
        .result (ld_data)
    );

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= ST_IDLE;
            ld_we_q <= 1'b0;
            ld_wa_q <= '0;
            ld_f3_q <= '0;
            ld_lo_q <= '0;
        end else begin
            if (acc_ld) begin
                state_q <= ST_LOAD_WAIT;
                ld_we_q <= mem_rd_we_i;
                ld_wa_q <= mem_rd_wa_i;
                ld_f3_q <= mem_ld_funct3_i;
                ld_lo_q <= mem_addr_lo_i;
            end else if (rsp_hit) begin
                state_q <= ST_IDLE;
            end
        end
    end

    // A non-load accepted alongside a load response (or behind one
    // already deferred) is held one cycle so writes stay in order.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            pnd_v_q  <= 1'b0;
            pnd_we_q <= 1'b0;
            pnd_wa_q <= '0;
            pnd_wd_q <= '0;
        end else begin
            pnd_v_q <= acc_alu & (pnd_v_q | rsp_hit);
            if (acc_alu) begin
                pnd_we_q <= alu_we;
                pnd_wa_q <= mem_rd_wa_i;
                pnd_wd_q <= mem_rd_wd_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            rd_we_o   <= 1'b0;
            rd_wa_o   <= '0;
            rd_wd_o   <= '0;
            retire_o  <= 1'b0;
            instret_o <= '0;
        end else begin
            rd_we_o  <= 1'b0;
            retire_o <= commit;
            if (pnd_v_q) begin
                rd_we_o <= pnd_we_q;
                rd_wa_o <= pnd_wa_q;
                rd_wd_o <= pnd_wd_q;
            end else if (rsp_hit) begin
                rd_we_o <= ld_we_q & (ld_wa_q != '0);
                rd_wa_o <= ld_wa_q;
                rd_wd_o <= ld_data;
            end else if (acc_alu) begin
                rd_we_o <= alu_we;
                rd_wa_o <= mem_rd_wa_i;
                rd_wd_o <= mem_rd_wd_i;
            end
            if (commit) begin
                instret_o <= instret_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios plus a
// randomized run against an in-order commit queue model.
module tb_wb_commit;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic        flush_i;
    logic        mem_rd_we_i;
    logic [4:0]  mem_rd_wa_i;
    logic [31:0] mem_rd_wd_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_ld_funct3_i;
    logic [1:0]  mem_addr_lo_i;
    logic        dmem_rsp_valid_i;
    logic [31:0] dmem_rsp_data_i;
    logic        rd_we_o;
    logic [4:0]  rd_wa_o;
    logic [31:0] rd_wd_o;
    logic        retire_o;
    logic [63:0] instret_o;

    logic        s_ready;
    logic        s_we;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic        s_retire;
    logic [3:0]  s_instret;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_cnt = '0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } cm_t;

    always #5 clk_i = ~clk_i;

    wb_commit dut (
        .clk_i           (clk_i),
        .n_rst_i         (n_rst_i),
        .mem_valid_i     (mem_valid_i),
        .mem_ready_o     (mem_ready_o),
        .flush_i         (flush_i),
        .mem_rd_we_i     (mem_rd_we_i),
        .mem_rd_wa_i     (mem_rd_wa_i),
        .mem_rd_wd_i     (mem_rd_wd_i),
        .mem_is_load_i   (mem_is_load_i),
        .mem_ld_funct3_i (mem_ld_funct3_i),
        .mem_addr_lo_i   (mem_addr_lo_i),
        .dmem_rsp_valid_i(dmem_rsp_valid_i),
        .dmem_rsp_data_i (dmem_rsp_data_i),
        .rd_we_o         (rd_we_o),
        .rd_wa_o         (rd_wa_o),
        .rd_wd_o         (rd_wd_o),
        .retire_o        (retire_o),
        .instret_o       (instret_o)
    );

    wb_commit #(.CNT_W(4)) u_small (
        .clk_i           (clk_i),
        .n_rst_i         (n_rst_i),
        .mem_valid_i     (mem_valid_i),
        .mem_ready_o     (s_ready),
        .flush_i         (flush_i),
        .mem_rd_we_i     (mem_rd_we_i),
        .mem_rd_wa_i     (mem_rd_wa_i),
        .mem_rd_wd_i     (mem_rd_wd_i),
        .mem_is_load_i   (mem_is_load_i),
        .mem_ld_funct3_i (mem_ld_funct3_i),
        .mem_addr_lo_i   (mem_addr_lo_i),
        .dmem_rsp_valid_i(dmem_rsp_valid_i),
        .dmem_rsp_data_i (dmem_rsp_data_i),
        .rd_we_o         (s_we),
        .rd_wa_o         (s_wa),
        .rd_wd_o         (s_wd),
        .retire_o        (s_retire),
        .instret_o       (s_instret)
    );

    function automatic logic [31:0] ref_align(input logic [2:0] f3,
                                              input logic [1:0] lo,
                                              input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * lo)) & 32'h0000_00FF;
        h = (d >> (16 * lo[1])) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    task automatic drive(input logic v, input logic fl, input logic ld,
                         input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input logic [1:0] lo, input logic rsp,
                         input logic [31:0] rdata);
        mem_valid_i      = v;
        flush_i          = fl;
        mem_is_load_i    = ld;
        mem_rd_we_i      = we;
        mem_rd_wa_i      = wa;
        mem_rd_wd_i      = wd;
        mem_ld_funct3_i  = f3;
        mem_addr_lo_i    = lo;
        dmem_rsp_valid_i = rsp;
        dmem_rsp_data_i  = rdata;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        idle();
        n_rst_i = 1'b0;
        #3;
        total++; if (rd_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rd_we_o); end
        total++; if (rd_wa_o !== 5'd0) begin bad++; $display("FAIL reset_wa got=%h exp=0", rd_wa_o); end
        total++; if (rd_wd_o !== 32'h0) begin bad++; $display("FAIL reset_wd got=%h exp=0", rd_wd_o); end
        total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL reset_retire got=%b exp=0", retire_o); end
        total++; if (instret_o !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", instret_o); end
        total++; if (mem_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", mem_ready_o); end
        tick();
        tick();
        n_rst_i = 1'b1;
        exp_cnt = '0;
        tick();
    endtask

    task automatic test_alu();
        drive(1, 0, 0, 1, 5'd5, 32'h1234, 3'd0, 2'd0, 0, 32'h0);
        #1;
        total++; if (mem_ready_o !== 1'b1) begin bad++; $display("FAIL alu_ready got=%b exp=1", mem_ready_o); end
        tick();
        idle();
        exp_cnt++;
        total++; if (rd_we_o !== 1'b1) begin bad++; $display("FAIL alu_we got=%b exp=1", rd_we_o); end
        total++; if (rd_wa_o !== 5'd5) begin bad++; $display("FAIL alu_wa got=%0d exp=5", rd_wa_o); end
        total++; if (rd_wd_o !== 32'h0000_1234) begin bad++; $display("FAIL alu_wd got=%h exp=00001234", rd_wd_o); end
        total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL alu_retire got=%b exp=1", retire_o); end
        tick();
        total++; if (retire_o !== 1'b0 || rd_we_o !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%b%b exp=00", retire_o, rd_we_o); end
        total++; if (instret_o !== exp_cnt) begin bad++; $display("FAIL alu_instret got=%0d exp=%0d", instret_o, exp_cnt); end
    endtask

    task automatic test_load();
        drive(1, 0, 1, 1, 5'd6, 32'h0, 3'b000, 2'd3, 0, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (mem_ready_o !== 1'b0) begin bad++; $display("FAIL lb_wait_ready got=%b exp=0", mem_ready_o); end
            total++; if (rd_we_o !== 1'b0 || retire_o !== 1'b0) begin bad++; $display("FAIL lb_wait_out got=%b%b exp=00", rd_we_o, retire_o); end
            tick();
        end
        drive(0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 1, 32'h80FF_FF00);
        #1;
        total++; if (mem_ready_o !== 1'b1) begin bad++; $display("FAIL lb_rsp_ready got=%b exp=1", mem_ready_o); end
        tick();
        idle();
        exp_cnt++;
        total++; if (rd_we_o !== 1'b1 || rd_wa_o !== 5'd6) begin bad++; $display("FAIL lb_we got=%b/%0d exp=1/6", rd_we_o, rd_wa_o); end
        total++; if (rd_wd_o !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_wd got=%h exp=ffffff80", rd_wd_o); end
        total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL lb_retire got=%b exp=1", retire_o); end
        tick();
        total++; if (retire_o !== 1'b0 || rd_we_o !== 1'b0) begin bad++; $display("FAIL lb_pulse got=%b%b exp=00", retire_o, rd_we_o); end
    endtask

    task automatic test_align();
        logic [2:0]  f3 [4];
        logic [1:0]  lo [4];
        logic [31:0] ex [4];
        f3[0] = 3'b101; lo[0] = 2'd2; ex[0] = 32'h0000_BEEF;
        f3[1] = 3'b001; lo[1] = 2'd2; ex[1] = 32'hFFFF_BEEF;
        f3[2] = 3'b010; lo[2] = 2'd0; ex[2] = 32'hBEEF_0000;
        f3[3] = 3'b100; lo[3] = 2'd3; ex[3] = 32'h0000_00BE;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 1, 5'(7 + i), 32'h0, f3[i], lo[i], 0, 32'h0);
            tick();
            drive(0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 1, 32'hBEEF_0000);
            tick();
            idle();
            exp_cnt++;
            total++; if (rd_wd_o !== ex[i] || rd_we_o !== 1'b1) begin bad++; $display("FAIL align_%0d got=%h we=%b exp=%h", i, rd_wd_o, rd_we_o, ex[i]); end
        end
        tick();
        total++; if (instret_o !== exp_cnt) begin bad++; $display("FAIL align_instret got=%0d exp=%0d", instret_o, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 1, 1, 5'd9, 32'h0, 3'b010, 2'd0, 0, 32'h0);
        tick();
        drive(1, 0, 0, 1, 5'd10, 32'h55, 3'd0, 2'd0, 1, 32'hCAFE_F00D);
        #1;
        total++; if (mem_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", mem_ready_o); end
        tick();
        idle();
        total++; if (rd_we_o !== 1'b1 || rd_wa_o !== 5'd9 || rd_wd_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_load got=%b/%0d/%h exp=1/9/cafef00d", rd_we_o, rd_wa_o, rd_wd_o); end
        tick();
        exp_cnt += 2;
        total++; if (rd_we_o !== 1'b1 || rd_wa_o !== 5'd10 || rd_wd_o !== 32'h55) begin bad++; $display("FAIL b2b_alu got=%b/%0d/%h exp=1/10/55", rd_we_o, rd_wa_o, rd_wd_o); end
        total++; if (retire_o !== 1'b1 || instret_o !== exp_cnt) begin bad++; $display("FAIL b2b_instret got=%b/%0d exp=1/%0d", retire_o, instret_o, exp_cnt); end
        tick();
        total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b exp=0", retire_o); end
    endtask

    task automatic test_x0_flush();
        drive(1, 0, 0, 1, 5'd0, 32'h77, 3'd0, 2'd0, 0, 32'h0);
        tick();
        idle();
        exp_cnt++;
        total++; if (rd_we_o !== 1'b0 || retire_o !== 1'b1) begin bad++; $display("FAIL x0 got=we%b ret%b exp=we0 ret1", rd_we_o, retire_o); end
        drive(1, 1, 0, 1, 5'd3, 32'h99, 3'd0, 2'd0, 0, 32'h0);
        tick();
        idle();
        total++; if (rd_we_o !== 1'b0 || retire_o !== 1'b0) begin bad++; $display("FAIL flush_alu got=we%b ret%b exp=00", rd_we_o, retire_o); end
        total++; if (instret_o !== exp_cnt) begin bad++; $display("FAIL flush_instret got=%0d exp=%0d", instret_o, exp_cnt); end
        drive(1, 0, 1, 1, 5'd12, 32'h0, 3'b010, 2'd0, 0, 32'h0);
        tick();
        drive(0, 1, 0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 1, 32'h1357_9BDF);
        tick();
        idle();
        exp_cnt++;
        total++; if (rd_we_o !== 1'b1 || rd_wd_o !== 32'h1357_9BDF) begin bad++; $display("FAIL flush_load got=%b/%h exp=1/13579bdf", rd_we_o, rd_wd_o); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        drive(1, 0, 1, 1, 5'd14, 32'h0, 3'b010, 2'd0, 0, 32'h0);
        tick();
        idle();
        #2;
        n_rst_i = 1'b0;
        #2;
        total++; if (instret_o !== 64'd0 || mem_ready_o !== 1'b1) begin bad++; $display("FAIL rst_mid got=%0d/%b exp=0/1", instret_o, mem_ready_o); end
        n_rst_i = 1'b1;
        exp_cnt = '0;
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 1, 32'hDEAD_BEEF);
        tick();
        idle();
        total++; if (rd_we_o !== 1'b0 || retire_o !== 1'b0) begin bad++; $display("FAIL late_rsp got=%b%b exp=00", rd_we_o, retire_o); end
        total++; if (instret_o !== 64'd0) begin bad++; $display("FAIL late_rsp_instret got=%0d exp=0", instret_o); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 1, 5'd1, 32'(i), 3'd0, 2'd0, 0, 32'h0);
            tick();
            exp_cnt++;
            if (i == 14) begin
                total++; if (s_instret !== 4'd15) begin bad++; $display("FAIL wrap_max got=%0d exp=15", s_instret); end
            end
        end
        idle();
        total++; if (s_instret !== 4'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", s_instret); end
        total++; if (instret_o !== exp_cnt) begin bad++; $display("FAIL wrap_wide got=%0d exp=%0d", instret_o, exp_cnt); end
        tick();
    endtask

    task automatic test_random();
        logic        m_pend = 1'b0;
        logic        m_we = 1'b0;
        logic [4:0]  m_wa = '0;
        logic [2:0]  m_f3 = '0;
        logic [1:0]  m_lo = '0;
        cm_t         q[$];
        cm_t         e;
        logic        v, fl, ld, we, rsp, exp_rdy, acc, have;
        logic [4:0]  wa;
        logic [31:0] wd, rdata;
        logic [2:0]  f3;
        logic [1:0]  lo;
        for (int c = 0; c < 1500; c++) begin
            v     = ($urandom_range(0, 99) < 70);
            fl    = ($urandom_range(0, 99) < 10);
            ld    = ($urandom_range(0, 99) < 35);
            we    = ($urandom_range(0, 99) < 80);
            wa    = 5'($urandom);
            wd    = $urandom;
            f3    = 3'($urandom);
            lo    = 2'($urandom);
            rsp   = m_pend ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
            rdata = $urandom;
            drive(v, fl, ld, we, wa, wd, f3, lo, rsp, rdata);
            #1;
            exp_rdy = !m_pend || rsp;
            total++; if (mem_ready_o !== exp_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, mem_ready_o, exp_rdy); end
            acc = v && !fl && exp_rdy;
            if (m_pend && rsp) begin
                q.push_back('{m_we && (m_wa != 0), m_wa, ref_align(m_f3, m_lo, rdata)});
                m_pend = 1'b0;
            end
            if (acc && ld) begin
                m_pend = 1'b1;
                m_we = we; m_wa = wa; m_f3 = f3; m_lo = lo;
            end else if (acc) begin
                q.push_back('{we && (wa != 0), wa, wd});
            end
            have = (q.size() > 0);
            if (have) begin
                e = q.pop_front();
                exp_cnt++;
            end
            tick();
            total++; if (retire_o !== have) begin bad++; $display("FAIL rnd_retire c=%0d got=%b exp=%b", c, retire_o, have); end
            total++; if (rd_we_o !== (have && e.we)) begin bad++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, rd_we_o, have && e.we); end
            if (have) begin
                total++; if (rd_wa_o !== e.wa || rd_wd_o !== e.wd) begin bad++; $display("FAIL rnd_data c=%0d got=%0d/%h exp=%0d/%h", c, rd_wa_o, rd_wd_o, e.wa, e.wd); end
            end
            total++; if (instret_o !== exp_cnt || s_instret !== exp_cnt[3:0]) begin bad++; $display("FAIL rnd_instret c=%0d got=%0d/%0d exp=%0d", c, instret_o, s_instret, exp_cnt); end
        end
        idle();
    endtask

    initial begin
        n_rst_i = 1'b0;
        idle();
        test_reset();
        test_alu();
        test_load();
        test_align();
        test_back_to_back();
        test_x0_flush();
        test_reset_mid_load();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
